// File: rtl/svc_rv_btb_pkg.sv
// Shared BTB/BHT types: 2-bit saturating counter encoding and prediction helper.
package svc_rv_btb_pkg;

  typedef logic [1:0] btb_cnt_t;

  localparam btb_cnt_t CNT_SNT = 2'd0;
  localparam btb_cnt_t CNT_WNT = 2'd1;
  localparam btb_cnt_t CNT_WT  = 2'd2;
  localparam btb_cnt_t CNT_ST  = 2'd3;

  function automatic logic cnt_predicts_taken(input btb_cnt_t cnt);
    return cnt[1];
  endfunction

endpackage

// File: rtl/svc_rv_btb_ctr.sv
// 2-bit saturating counter next-state; purely combinational, no backpressure.
module svc_rv_btb_ctr
  import svc_rv_btb_pkg::*;
(
  input  btb_cnt_t cnt,
  input  logic     taken,
  output btb_cnt_t cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != CNT_ST) cnt_next = btb_cnt_t'(cnt + 2'd1);
    end else begin
      if (cnt != CNT_SNT) cnt_next = btb_cnt_t'(cnt - 2'd1);
    end
  end

endmodule

// File: rtl/svc_rv_btb.sv
// Direct-mapped BTB: 1-cycle registered lookup aligned with imem data, trained from EX; no stall input.
// SVC_RV_BTB_BYPASS_EN forwards a same-cycle matching update to the lookup result.
module svc_rv_btb
  import svc_rv_btb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_en,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            upd_is_jump,
  input  logic            flush
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    btb_cnt_t         cnt;
    logic             jmp;
  } entry_t;

  logic [BTB_ENTRIES-1:0] r_valid;
  entry_t                 r_entry [BTB_ENTRIES];

  logic                   r_pred_hit;
  logic                   r_pred_taken;
  logic [XLEN-1:0]        r_pred_target;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  entry_t           w_lk_ent;
  entry_t           w_up_ent;
  entry_t           w_up_new;
  btb_cnt_t         w_cnt_next;
  logic             w_lk_hit;
  logic             w_up_hit;
  logic             w_up_we;
  logic             w_hit;
  entry_t           w_ent;
  logic             w_unused;

  assign w_lk_idx = lookup_pc[IDX_W+1:2];
  assign w_lk_tag = lookup_pc[XLEN-1:IDX_W+2];
  assign w_up_idx = upd_pc[IDX_W+1:2];
  assign w_up_tag = upd_pc[XLEN-1:IDX_W+2];
  assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign w_lk_ent = r_entry[w_lk_idx];
  assign w_up_ent = r_entry[w_up_idx];
  assign w_lk_hit = r_valid[w_lk_idx] && (w_lk_ent.tag == w_lk_tag);
  assign w_up_hit = r_valid[w_up_idx] && (w_up_ent.tag == w_up_tag);

  svc_rv_btb_ctr u_ctr (
    .cnt      (w_up_ent.cnt),
    .taken    (upd_taken),
    .cnt_next (w_cnt_next)
  );

  // Miss-not-taken leaves the entry untouched; everything else rewrites it.
  assign w_up_we = upd_valid && (w_up_hit || upd_taken);

  always_comb begin
    w_up_new        = w_up_ent;
    w_up_new.tag    = w_up_tag;
    w_up_new.cnt    = w_up_hit ? w_cnt_next : CNT_WT;
    if (upd_taken) begin
      w_up_new.target = upd_target;
      w_up_new.jmp    = upd_is_jump;
    end
  end

`ifdef SVC_RV_BTB_BYPASS_EN
  logic w_byp;
  assign w_byp = w_up_we && !flush && (w_up_idx == w_lk_idx) && (w_up_tag == w_lk_tag);
  assign w_hit = w_byp || w_lk_hit;
  assign w_ent = w_byp ? w_up_new : w_lk_ent;
`else
  assign w_hit = w_lk_hit;
  assign w_ent = w_lk_ent;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= '0;
      r_pred_hit    <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else begin
      if (flush) begin
        r_valid <= '0;
      end else if (w_up_we) begin
        r_valid[w_up_idx] <= 1'b1;
      end
      r_pred_hit    <= lookup_en && !flush && w_hit;
      r_pred_taken  <= lookup_en && !flush && w_hit && (cnt_predicts_taken(w_ent.cnt) || w_ent.jmp);
      r_pred_target <= (lookup_en && !flush && w_hit) ? w_ent.target : '0;
    end
  end

  // Payload is don't-care until its valid bit is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_up_we) begin
      r_entry[w_up_idx] <= w_up_new;
    end
  end

  assign pred_hit    = r_pred_hit;
  assign pred_taken  = r_pred_taken;
  assign pred_target = r_pred_target;

endmodule

// File: tb/tb_svc_rv_btb.sv
// Directed bench for svc_rv_btb with hand-computed expectations (BTB_ENTRIES=16).
module tb_svc_rv_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_is_jump;
  logic        flush;

  int n_cmp  = 0;
  int n_fail = 0;

  svc_rv_btb #(.XLEN(32), .BTB_ENTRIES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .lookup_en   (lookup_en),
    .lookup_pc   (lookup_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
    .upd_is_jump (upd_is_jump),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic e_hit, input logic e_taken, input logic [31:0] e_tgt);
    n_cmp++;
    assert (pred_hit === e_hit) else begin
      n_fail++;
      $error("FAIL %s pred_hit: got %b want %b", name, pred_hit, e_hit);
    end
    n_cmp++;
    assert (pred_taken === e_taken) else begin
      n_fail++;
      $error("FAIL %s pred_taken: got %b want %b", name, pred_taken, e_taken);
    end
    n_cmp++;
    assert (pred_target === e_tgt) else begin
      n_fail++;
      $error("FAIL %s pred_target: got %h want %h", name, pred_target, e_tgt);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic jmp);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_target  = tgt;
    upd_taken   = tk;
    upd_is_jump = jmp;
    tick();
    upd_valid   = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_en = 1'b1;
    lookup_pc = pc;
    tick();
    lookup_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lookup_en = 1'b0; lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_target = '0; upd_taken = 1'b0; upd_is_jump = 1'b0; flush = 1'b0;
    #2;
    chk("reset", 1'b0, 1'b0, 32'h0);
    tick(); tick();
    rst = 1'b0;

    look(32'h100);
    chk("cold_miss", 1'b0, 1'b0, 32'h0);

    // Allocate 0x100 (idx0, tag4) weakly taken; outputs idle while lookup_en=0.
    upd(32'h100, 32'h080, 1'b1, 1'b0);
    chk("lookup_en_low", 1'b0, 1'b0, 32'h0);
    look(32'h100);
    chk("alloc_hit", 1'b1, 1'b1, 32'h080);
    look(32'h140);
    chk("tag_mismatch", 1'b0, 1'b0, 32'h0);

    // cnt 2 -> 1 -> 0
    upd(32'h100, 32'h0, 1'b0, 1'b0);
    upd(32'h100, 32'h0, 1'b0, 1'b0);
    look(32'h100);
    chk("cnt0_not_taken", 1'b1, 1'b0, 32'h080);

    // cnt 0 -> 1 -> 2 -> 3 -> 3
    for (int i = 0; i < 4; i++) upd(32'h100, 32'h080, 1'b1, 1'b0);
    look(32'h100);
    chk("cnt_sat3", 1'b1, 1'b1, 32'h080);
    upd(32'h100, 32'h0, 1'b0, 1'b0);
    look(32'h100);
    chk("cnt3_dec_to2", 1'b1, 1'b1, 32'h080);
    upd(32'h100, 32'h0, 1'b0, 1'b0);
    look(32'h100);
    chk("cnt2_dec_to1", 1'b1, 1'b0, 32'h080);

    // cnt 1 -> 0 -> 0 -> 0, then +1 -> 1 (still not taken)
    for (int i = 0; i < 3; i++) upd(32'h100, 32'h0, 1'b0, 1'b0);
    upd(32'h100, 32'h090, 1'b1, 1'b0);
    look(32'h100);
    chk("cnt_sat0_then_inc", 1'b1, 1'b0, 32'h090);

    // Jump at 0x200 replaces idx0; counter driven to 0 but jump stays taken.
    upd(32'h200, 32'h400, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) upd(32'h200, 32'h0, 1'b0, 1'b0);
    look(32'h200);
    chk("jump_taken_cnt0", 1'b1, 1'b1, 32'h400);
    look(32'h100);
    chk("replaced_miss", 1'b0, 1'b0, 32'h0);

    // Same-cycle lookup and first-time taken update of 0x300.
    lookup_en = 1'b1; lookup_pc = 32'h300;
    upd(32'h300, 32'h500, 1'b1, 1'b0);
    lookup_en = 1'b0;
`ifdef SVC_RV_BTB_BYPASS_EN
    chk("same_cycle_bypass", 1'b1, 1'b1, 32'h500);
`else
    chk("same_cycle_old", 1'b0, 1'b0, 32'h0);
`endif
    look(32'h300);
    chk("after_same_cycle", 1'b1, 1'b1, 32'h500);

    // Populate idx1..3, then flush together with an update to idx4.
    upd(32'h104, 32'h600, 1'b1, 1'b0);
    upd(32'h108, 32'h700, 1'b1, 1'b0);
    upd(32'h10C, 32'h800, 1'b1, 1'b1);
    look(32'h10C);
    chk("populated", 1'b1, 1'b1, 32'h800);
    flush = 1'b1;
    upd(32'h110, 32'h900, 1'b1, 1'b0);
    flush = 1'b0;
    look(32'h300); chk("flush_miss_300", 1'b0, 1'b0, 32'h0);
    look(32'h104); chk("flush_miss_104", 1'b0, 1'b0, 32'h0);
    look(32'h108); chk("flush_miss_108", 1'b0, 1'b0, 32'h0);
    look(32'h10C); chk("flush_miss_10C", 1'b0, 1'b0, 32'h0);
    look(32'h110); chk("flush_upd_dropped", 1'b0, 1'b0, 32'h0);

    // Async reset mid-cycle while an update is pending.
    upd(32'h104, 32'h600, 1'b1, 1'b0);
    look(32'h104);
    chk("pre_rst_hit", 1'b1, 1'b1, 32'h600);
    #2;
    upd_valid = 1'b1; upd_pc = 32'h108; upd_target = 32'h700; upd_taken = 1'b1; upd_is_jump = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst", 1'b0, 1'b0, 32'h0);
    tick();
    upd_valid = 1'b0;
    rst = 1'b0;
    look(32'h104); chk("rst_cleared", 1'b0, 1'b0, 32'h0);
    look(32'h108); chk("rst_upd_dropped", 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/svc_rv_btb.md
Name: svc_rv_btb

Overview:
- Direct-mapped branch target buffer (BTB) for the pipelined RV core.
- Sits upstream of the SRAM instruction fetch. It is looked up with the fetch PC and returns a registered predicted-taken flag and target one cycle later, aligned with SRAM imem read data.
- Trained by resolved branches/jumps from EX.
- Each entry holds valid, tag, target and a 2-bit saturating counter.

Parameters:
- XLEN, 32, address/data width.
- BTB_ENTRIES, 16, number of entries; power of two, at least 2.
- IDX_W, $clog2(BTB_ENTRIES), index width (derived, localparam).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- lookup_en  in  1  fetch issues a lookup this cycle
- lookup_pc  in  XLEN  fetch PC
- pred_hit  out  1  registered: tag match on the previous cycle's lookup
- pred_taken  out  1  registered: hit AND (counter[1] OR is_jump)
- pred_target  out  XLEN  registered target; 0 when not hit
- upd_valid  in  1  resolved control-flow instruction from EX
- upd_pc  in  XLEN  PC of the resolved instruction
- upd_target  in  XLEN  resolved target
- upd_taken  in  1  actual direction
- upd_is_jump  in  1  unconditional (JAL/JALR)
- flush  in  1  invalidate all entries (fence.i / debug reload)

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2]
  - tag = pc[XLEN-1:IDX_W+2]
  - pc[1:0] ignored
- Storage: per entry valid, tag, target, cnt[1:0], jmp.
  - Only valid bits are reset.
  - Tag, target, cnt and jmp are don't-care until written.
- Reset (async, rst=1):
  - all valid=0
  - pred_hit=0, pred_taken=0, pred_target=0
- Lookup latency is exactly 1 cycle:
  - outputs at N+1 reflect lookup_en/lookup_pc sampled at N.
  - lookup_en=0 at N: all pred_* outputs are 0 at N+1.
- Update, applied at the clock edge:
  - Hit, taken: cnt=sat_inc(cnt), target=upd_target, jmp=upd_is_jump.
  - Hit, not taken: cnt=sat_dec(cnt).
  - Miss, taken: allocate/replace; valid=1, tag, target, jmp; cnt=2'b10 (weakly taken).
  - Miss, not taken: no change.
- Counter saturates: 3 stays 3 on inc; 0 stays 0 on dec.
- Simultaneous lookup and update to the same idx (macro absent): lookup returns pre-update contents.
- flush:
  - all valid=0 at the edge; pred_* outputs 0 on the next cycle.
  - Flush wins over a same-cycle update.
- rst mid-operation: state is cleared immediately; any update in that cycle is dropped.
- No stall input: the caller holds lookup_pc and re-asserts lookup_en to repeat a lookup.

Optional Feature:
- Macro: SVC_RV_BTB_BYPASS_EN.
- Defined: an update whose idx and tag equal the same-cycle lookup is forwarded.
  - pred_* at N+1 reflect the post-update entry: hit/target/cnt/jmp as written.
  - A not-taken update on a hit forwards the decremented counter.
  - A same-cycle flush suppresses the bypass.
- Undefined: old-contents semantics as stated in Behaviour.

Decomposition:
- Package svc_rv_btb_pkg:
  - typedef btb_cnt_t (logic [1:0])
  - constants CNT_SNT=0, CNT_WNT=1, CNT_WT=2, CNT_ST=3
  - parameterized entry struct {tag, target, cnt, jmp}
- Sub-module svc_rv_btb_ctr: combinational 2-bit saturating next-state.
  - Inputs: cnt, taken. Output: cnt_next.
  - Shared with a later BHT.

Test Plan:
- Reset, then lookup pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0 one cycle later.
- Update pc=0x100, target=0x080, taken=1, then lookup 0x100 -> hit=1, taken=1 (cnt=2), target=0x080. Lookup 0x140 (same idx when BTB_ENTRIES=16, different tag) -> hit=0.
- Counter training: from cnt=2, two not-taken updates -> cnt=0, taken=0, hit=1. Four taken updates -> cnt=3 (saturation), taken=1. Then one not-taken -> cnt=2, still taken.
- Jump entry: upd_is_jump=1 at pc=0x200, then three not-taken updates (cnt reaches 0) -> pred_taken stays 1.
- Same-cycle lookup and update of pc=0x300, first time taken -> pred_hit=0 without macro; pred_hit=1 with target=upd_target when SVC_RV_BTB_BYPASS_EN is defined.
- Populate 4 entries, pulse flush concurrently with an update -> all subsequent lookups miss. Assert rst mid-stream -> pred_* go to 0 asynchronously.
